flap_position_controller: RTL and testbench

FLAP_POSITION_CONTROLLER -- requirements
Module: flap_position_controller

---
 rtl/flap_pkg.sv | 41 ++++
 rtl/flap_travel_timer.sv | 33 +++
 rtl/flap_position_controller.sv | 109 ++++++++++
 tb/tb_flap_position_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/flap_pkg.sv
// Shared definitions for the flap position controller.
// Holds the position encoding, the FSM state type and small position helpers.
package flap_pkg;

    typedef enum logic [1:0] {
        POS_UP      = 2'd0,
        POS_HOR     = 2'd1,
        POS_DOWN    = 2'd2,
        POS_INVALID = 2'd3
    } flap_pos_t;

    typedef enum logic {
        ST_IDLE,
        ST_MOVE
    } flap_state_t;

    // One-hot indicator ordered {down, hor, up}.
    function automatic logic [2:0] pos_onehot(flap_pos_t pos);
        logic [2:0] onehot;
        onehot = 3'b000;
        case (pos)
            POS_UP:   onehot = 3'b001;
            POS_HOR:  onehot = 3'b010;
            POS_DOWN: onehot = 3'b100;
            default:  onehot = 3'b000;
        endcase
        return onehot;
    endfunction

    function automatic flap_pos_t step_toward(flap_pos_t pos, flap_pos_t tgt);
        flap_pos_t next_pos;
        next_pos = pos;
        if (tgt > pos) begin
            next_pos = flap_pos_t'(pos + 2'd1);
        end else if (tgt < pos) begin
            next_pos = flap_pos_t'(pos - 2'd1);
        end
        return next_pos;
    endfunction

endpackage

// File: rtl/flap_travel_timer.sv
// Per-step travel timer: loads TRAVEL_CYCLES-1 and counts down to zero.
// done is high whenever the count has reached zero.
module flap_travel_timer
    import flap_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 1000
) (
    input  logic clk,
    input  logic async_reset,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam int CW = $clog2(TRAVEL_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(TRAVEL_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Load wins over count so a step can immediately rearm the next one.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/flap_position_controller.sv
// Three-position flap controller arbitrating pilot and autopilot requests
// and driving the motor one position step per TRAVEL_CYCLES cycles.
module flap_position_controller
    import flap_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       async_reset,
    input  logic       req_pilot,
    input  logic [1:0] target_pilot,
    input  logic       req_ap,
    input  logic [1:0] target_ap,
    output logic       ack_pilot,
    output logic       ack_ap,
    output logic       err,
    output logic       motor_extend,
    output logic       motor_retract,
    output logic       busy,
    output logic       up,
    output logic       hor,
    output logic       down
);

    flap_state_t state;
    flap_pos_t   position;
    flap_pos_t   target_q;

    logic        accept;
    logic        sel_invalid;
    logic        start_move;
    flap_pos_t   sel_target;
    flap_pos_t   next_pos;
    logic        arrive;
    logic        timer_load;
    logic        timer_count;
    logic        timer_done;

    // Pilot has priority; the losing autopilot request simply stays pending.
    always_comb begin
        sel_target  = flap_pos_t'(req_pilot ? target_pilot : target_ap);
        accept      = (state == ST_IDLE) && (req_pilot || req_ap);
        sel_invalid = (sel_target == POS_INVALID);
        start_move  = accept && !sel_invalid && (sel_target != position);
        next_pos    = step_toward(position, target_q);
        arrive      = (next_pos == target_q);
        timer_load  = start_move || ((state == ST_MOVE) && timer_done && !arrive);
        timer_count = (state == ST_MOVE) && !timer_done;
    end

    flap_travel_timer #(
        .TRAVEL_CYCLES(TRAVEL_CYCLES)
    ) u_timer (
        .clk         (clk),
        .async_reset (async_reset),
        .load        (timer_load),
        .count       (timer_count),
        .done        (timer_done)
    );

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state         <= ST_IDLE;
            position      <= POS_UP;
            target_q      <= POS_UP;
            ack_pilot     <= 1'b0;
            ack_ap        <= 1'b0;
            err           <= 1'b0;
            motor_extend  <= 1'b0;
            motor_retract <= 1'b0;
            busy          <= 1'b0;
            up            <= 1'b1;
            hor           <= 1'b0;
            down          <= 1'b0;
        end else begin
            ack_pilot <= accept && req_pilot;
            ack_ap    <= accept && !req_pilot;
            err       <= accept && sel_invalid;
            case (state)
                ST_IDLE: begin
                    if (start_move) begin
                        state         <= ST_MOVE;
                        target_q      <= sel_target;
                        busy          <= 1'b1;
                        motor_extend  <= (sel_target > position);
                        motor_retract <= (sel_target < position);
                    end
                end
                ST_MOVE: begin
                    // The settled indicators only change when a step completes.
                    if (timer_done) begin
                        position          <= next_pos;
                        {down, hor, up}   <= pos_onehot(next_pos);
                        if (arrive) begin
                            state         <= ST_IDLE;
                            busy          <= 1'b0;
                            motor_extend  <= 1'b0;
                            motor_retract <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flap_position_controller.sv
// Bench for flap_position_controller: directed scenarios followed by random
// requests, all compared cycle by cycle against a behavioural flap model.
module tb_flap_position_controller;

    localparam int T = 4;
    localparam logic [8:0] RESET_VEC = 9'b000000100;

    logic       clk;
    logic       async_reset;
    logic       req_pilot;
    logic [1:0] target_pilot;
    logic       req_ap;
    logic [1:0] target_ap;
    logic       ack_pilot;
    logic       ack_ap;
    logic       err;
    logic       motor_extend;
    logic       motor_retract;
    logic       busy;
    logic       up;
    logic       hor;
    logic       down;

    int assert_count = 0;
    int fail_count   = 0;
    int ext_cycles   = 0;
    int ack_seen     = 0;

    // Behavioural model: settled position, destination, cycles since move start.
    int m_pos;
    int m_tgt;
    int m_elapsed;
    bit m_moving;
    bit m_ack_p;
    bit m_ack_a;
    bit m_err;

    flap_position_controller #(
        .TRAVEL_CYCLES(T)
    ) dut (
        .clk           (clk),
        .async_reset   (async_reset),
        .req_pilot     (req_pilot),
        .target_pilot  (target_pilot),
        .req_ap        (req_ap),
        .target_ap     (target_ap),
        .ack_pilot     (ack_pilot),
        .ack_ap        (ack_ap),
        .err           (err),
        .motor_extend  (motor_extend),
        .motor_retract (motor_retract),
        .busy          (busy),
        .up            (up),
        .hor           (hor),
        .down          (down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_pos     = 0;
        m_tgt     = 0;
        m_elapsed = 0;
        m_moving  = 1'b0;
        m_ack_p   = 1'b0;
        m_ack_a   = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic model_edge();
        int t;
        m_ack_p = 1'b0;
        m_ack_a = 1'b0;
        m_err   = 1'b0;
        if (!m_moving) begin
            if (req_pilot || req_ap) begin
                t       = req_pilot ? int'(target_pilot) : int'(target_ap);
                m_ack_p = req_pilot;
                m_ack_a = !req_pilot;
                if (t == 3) begin
                    m_err = 1'b1;
                end else if (t != m_pos) begin
                    m_moving  = 1'b1;
                    m_tgt     = t;
                    m_elapsed = 0;
                end
            end
        end else begin
            m_elapsed++;
            if (m_elapsed % T == 0) begin
                m_pos = (m_tgt > m_pos) ? m_pos + 1 : m_pos - 1;
                if (m_pos == m_tgt) m_moving = 1'b0;
            end
        end
    endtask

    function automatic logic [8:0] model_vec();
        logic ext;
        logic ret;
        ext = m_moving && (m_tgt > m_pos);
        ret = m_moving && (m_tgt < m_pos);
        return {m_ack_p, m_ack_a, m_err, ext, ret, m_moving,
                m_pos == 0, m_pos == 1, m_pos == 2};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {ack_pilot, ack_ap, err, motor_extend, motor_retract, busy, up, hor, down};
    endfunction

    task automatic apply_stimulus(input logic rp, input logic [1:0] tp, input logic ra, input logic [1:0] ta);
        req_pilot    = rp;
        target_pilot = tp;
        req_ap       = ra;
        target_ap    = ta;
    endtask

    // One clock: advance the model, compare after the edge, let requesters see acks.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_output("outputs", dut_vec(), model_vec());
        check_output("motor_exclusive", {8'b0, motor_extend & motor_retract}, 9'b0);
        if (motor_extend) ext_cycles++;
        if (ack_pilot || ack_ap) ack_seen++;
        if (ack_pilot) req_pilot = 1'b0;
        if (ack_ap) req_ap = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset asserted mid-cycle so its effect must appear without a clock edge.
    task automatic pulse_reset();
        async_reset = 1'b1;
        req_pilot   = 1'b0;
        req_ap      = 1'b0;
        #1;
        check_output("async_reset", dut_vec(), RESET_VEC);
        @(posedge clk);
        #1;
        async_reset = 1'b0;
        model_reset();
    endtask

    initial begin
        async_reset = 1'b1;
        apply_stimulus(1'b0, 2'd0, 1'b0, 2'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", dut_vec(), RESET_VEC);
        async_reset = 1'b0;
        ticks(2);

        $display("[TB] pilot UP to DOWN");
        ext_cycles = 0;
        apply_stimulus(1'b1, 2'd2, 1'b0, 2'd0);
        ticks(12);
        check_output("extend_cycles", 9'(ext_cycles), 9'(2 * T));
        check_output("at_down", {6'b0, up, hor, down}, 9'b000000001);

        $display("[TB] pilot invalid target");
        apply_stimulus(1'b1, 2'd3, 1'b0, 2'd0);
        tick();
        check_output("err_with_ack", {7'b0, ack_pilot, err}, 9'b000000011);
        ticks(3);

        $display("[TB] reset mid-move from DOWN");
        apply_stimulus(1'b1, 2'd0, 1'b0, 2'd0);
        ticks(3);
        pulse_reset();
        ack_seen = 0;
        ticks(6);
        check_output("no_ack_after_reset", 9'(ack_seen), 9'd0);

        $display("[TB] autopilot target equals position");
        apply_stimulus(1'b0, 2'd0, 1'b1, 2'd0);
        tick();
        check_output("ap_same_pos", {6'b0, ack_ap, ack_pilot, busy}, 9'b000000100);
        ticks(2);

        $display("[TB] simultaneous pilot and autopilot");
        apply_stimulus(1'b1, 2'd1, 1'b1, 2'd2);
        tick();
        check_output("pilot_first", {7'b0, ack_pilot, ack_ap}, 9'b000000010);
        ticks(T + 2 * T + 3);
        check_output("ap_reached_down", {6'b0, up, hor, down}, 9'b000000001);

        $display("[TB] random phase");
        for (int c = 0; c < 600; c++) begin
            if (!req_pilot && ($urandom_range(7) == 0)) begin
                req_pilot    = 1'b1;
                target_pilot = 2'($urandom_range(3));
            end
            if (!req_ap && ($urandom_range(7) == 0)) begin
                req_ap    = 1'b1;
                target_ap = 2'($urandom_range(3));
            end
            if ($urandom_range(149) == 0) begin
                pulse_reset();
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
